// File: rtl/clock_time_counter.sv
// Time-of-day counter: HH:MM:SS in packed BCD, advanced by a 1 Hz tick,
// with a button-driven set mode for hours and minutes.
module clock_time_counter #(
  parameter bit FMT24 = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       pm,
  output logic [1:0] editing,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  localparam logic [7:0] HH_RESET = FMT24 ? 8'h00 : 8'h12;

  state_t     state_reg, state_next;
  logic [7:0] hh_reg, hh_next;
  logic [7:0] mm_reg, mm_next;
  logic [7:0] ss_reg, ss_next;
  logic       pm_reg, pm_next;
  logic       day_reg, day_next;

  // Minutes/seconds BCD increment, 59 wraps to 00.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v == 8'h59)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Hours BCD increment; result is {pm, hh}. In 12 h mode 11->12 flips pm
  // and 12->01 keeps it.
  function automatic logic [8:0] inc_hr(input logic [7:0] h, input logic p);
    if (FMT24) begin
      if (h == 8'h23)
        return {1'b0, 8'h00};
    end else begin
      if (h == 8'h12)
        return {p, 8'h01};
      if (h == 8'h11)
        return {~p, 8'h12};
    end
    if (h[3:0] == 4'd9)
      return {p, h[7:4] + 4'd1, 4'd0};
    return {p, h[7:4], h[3:0] + 4'd1};
  endfunction

  // Mode FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= RUN;
    else
      state_reg <= state_next;
  end

  // Next state and next time value; mode_btn always takes priority over inc_btn.
  always_comb begin
    state_next = state_reg;
    hh_next    = hh_reg;
    mm_next    = mm_reg;
    ss_next    = ss_reg;
    pm_next    = pm_reg;
    day_next   = 1'b0;
    case (state_reg)
      RUN: begin
        if (tick) begin
          ss_next = inc60(ss_reg);
          if (ss_reg == 8'h59) begin
            mm_next = inc60(mm_reg);
            if (mm_reg == 8'h59) begin
              {pm_next, hh_next} = inc_hr(hh_reg, pm_reg);
              // Midnight is 23->00, or 11 PM -> 12 AM in 12 h mode.
              day_next = FMT24 ? (hh_reg == 8'h23) : (hh_reg == 8'h11 && pm_reg);
            end
          end
        end
        if (mode_btn)
          state_next = SET_HR;
      end
      SET_HR: begin
        if (mode_btn)
          state_next = SET_MIN;
        else if (inc_btn)
          {pm_next, hh_next} = inc_hr(hh_reg, pm_reg);
      end
      SET_MIN: begin
        if (mode_btn) begin
          state_next = RUN;
          ss_next    = 8'h00;
        end else if (inc_btn) begin
          mm_next = inc60(mm_reg);
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Time registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh_reg  <= HH_RESET;
      mm_reg  <= 8'h00;
      ss_reg  <= 8'h00;
      pm_reg  <= 1'b0;
      day_reg <= 1'b0;
    end else begin
      hh_reg  <= hh_next;
      mm_reg  <= mm_next;
      ss_reg  <= ss_next;
      pm_reg  <= pm_next;
      day_reg <= day_next;
    end
  end

  assign hh_bcd    = hh_reg;
  assign mm_bcd    = mm_reg;
  assign ss_bcd    = ss_reg;
  assign pm        = FMT24 ? 1'b0 : pm_reg;
  assign editing   = state_reg;
  assign day_pulse = day_reg;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: a 24 h and a 12 h instance share stimulus.
// Expected values come from a table of hand-computed records and from a
// behavioural model that keeps hours as 0-23 and derives the 12 h view.
module tb_clock_time_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick = 1'b0;
  logic mode_btn = 1'b0;
  logic inc_btn = 1'b0;

  logic [7:0] hh24, mm24, ss24, hh12, mm12, ss12;
  logic       pm24, pm12, day24, day12;
  logic [1:0] ed24, ed12;

  clock_time_counter #(.FMT24(1'b1)) u24 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .hh_bcd(hh24), .mm_bcd(mm24), .ss_bcd(ss24), .pm(pm24), .editing(ed24),
    .day_pulse(day24)
  );

  clock_time_counter #(.FMT24(1'b0)) u12 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .hh_bcd(hh12), .mm_bcd(mm12), .ss_bcd(ss12), .pm(pm12), .editing(ed12),
    .day_pulse(day12)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hh;   // 0-23
    int mm;
    int ss;
    int ed;
    int day;
  } exp_t;

  typedef struct {
    logic t;
    logic m;
    logic i;
    int   hh;
    int   mm;
    int   ss;
    int   ed;
    int   day;
  } vec_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int nstep = 0;

  // model state
  int mh = 0, mmin = 0, msec = 0, mst = 0, mday = 0;

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int h12(input int h);
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s at step %0d: got %0h, want %0h", name, nstep, got, want);
    end
  endtask

  task automatic model_reset();
    mh = 0; mmin = 0; msec = 0; mst = 0; mday = 0;
  endtask

  task automatic model_step(input logic t, input logic m, input logic i);
    mday = 0;
    case (mst)
      0: begin
        if (t) begin
          msec++;
          if (msec == 60) begin
            msec = 0;
            mmin++;
            if (mmin == 60) begin
              mmin = 0;
              mh++;
              if (mh == 24) begin
                mh = 0;
                mday = 1;
              end
            end
          end
        end
        if (m) mst = 1;
      end
      1: begin
        if (m) mst = 2;
        else if (i) mh = (mh + 1) % 24;
      end
      default: begin
        if (m) begin
          mst = 0;
          msec = 0;
        end else if (i) begin
          mmin = (mmin + 1) % 60;
        end
      end
    endcase
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hh24"}, int'(hh24), 'h00);
    chk({tag, "_hh12"}, int'(hh12), 'h12);
    chk({tag, "_mm"}, int'(mm24) + int'(mm12), 0);
    chk({tag, "_ss"}, int'(ss24) + int'(ss12), 0);
    chk({tag, "_pm"}, int'(pm24) + int'(pm12), 0);
    chk({tag, "_ed"}, int'(ed24) + int'(ed12), 0);
    chk({tag, "_day"}, int'(day24) + int'(day12), 0);
  endtask

  // One clock: push expectation, drive inputs, pop and compare after the edge.
  task automatic step(input logic t, input logic m, input logic i,
                      input bit use_tab, input exp_t tab);
    exp_t e;
    model_step(t, m, i);
    if (use_tab) e = tab;
    else e = '{hh: mh, mm: mmin, ss: msec, ed: mst, day: mday};
    sbq.push_back(e);
    tick = t; mode_btn = m; inc_btn = i;
    @(posedge clk);
    #1;
    tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    nstep++;
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      chk("hh24", int'(hh24), bcd(e.hh));
      chk("mm24", int'(mm24), bcd(e.mm));
      chk("ss24", int'(ss24), bcd(e.ss));
      chk("pm24", int'(pm24), 0);
      chk("ed24", int'(ed24), e.ed);
      chk("day24", int'(day24), e.day);
      chk("hh12", int'(hh12), bcd(h12(e.hh)));
      chk("pm12", int'(pm12), (e.hh >= 12) ? 1 : 0);
      chk("mm12", int'(mm12), bcd(e.mm));
      chk("ss12", int'(ss12), bcd(e.ss));
      chk("ed12", int'(ed12), e.ed);
      chk("day12", int'(day12), e.day);
      $display("step %0d t=%0b m=%0b i=%0b -> %02h:%02h:%02h ed=%0d day=%0b | %02h:%02h:%02h pm=%0b",
               nstep, t, m, i, hh24, mm24, ss24, ed24, day24, hh12, mm12, ss12, pm12);
    end
  endtask

  task automatic run(input int n, input logic t, input logic m, input logic i);
    exp_t d;
    d = '{hh: 0, mm: 0, ss: 0, ed: 0, day: 0};
    for (int k = 0; k < n; k++) step(t, m, i, 1'b0, d);
  endtask

  // Async reset between clock edges, then release on the falling edge.
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 chk_reset(tag);
    model_reset();
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tab[12];

  initial begin
    exp_t te;
    tab[0]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 0};
    tab[1]  = '{1'b0, 1'b1, 1'b1, 0, 0, 1, 1, 0};
    tab[2]  = '{1'b0, 1'b0, 1'b1, 1, 0, 1, 1, 0};
    tab[3]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1, 1, 0};
    tab[4]  = '{1'b0, 1'b1, 1'b0, 1, 0, 1, 2, 0};
    tab[5]  = '{1'b0, 1'b0, 1'b1, 1, 1, 1, 2, 0};
    tab[6]  = '{1'b1, 1'b0, 1'b1, 1, 2, 1, 2, 0};
    tab[7]  = '{1'b0, 1'b1, 1'b1, 1, 2, 0, 0, 0};
    tab[8]  = '{1'b1, 1'b1, 1'b0, 1, 2, 1, 1, 0};
    tab[9]  = '{1'b0, 1'b1, 1'b0, 1, 2, 1, 2, 0};
    tab[10] = '{1'b0, 1'b1, 1'b0, 1, 2, 0, 0, 0};
    tab[11] = '{1'b1, 1'b0, 1'b0, 1, 2, 1, 0, 0};

    // power-on reset, no clock edge yet
    #1 rst_n = 1'b0;
    #1 chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table of basic and simultaneous-event vectors
    for (int k = 0; k < 12; k++) begin
      te = '{hh: tab[k].hh, mm: tab[k].mm, ss: tab[k].ss, ed: tab[k].ed, day: tab[k].day};
      step(tab[k].t, tab[k].m, tab[k].i, 1'b1, te);
    end

    // async reset mid-count, then 60 ticks -> 00:01:00
    async_reset("midrst");
    run(60, 1'b1, 1'b0, 1'b0);
    chk("one_min_mm", int'(mm24), 'h01);
    chk("one_min_ss", int'(ss24), 'h00);

    // preload 23:59:58, then roll over midnight
    async_reset("rst2");
    run(1, 1'b0, 1'b1, 1'b0);
    run(23, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b1, 1'b0);
    run(59, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b1, 1'b0);
    run(58, 1'b1, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0);
    chk("pre_mid_hh", int'(hh24), 'h23);
    run(1, 1'b1, 1'b0, 1'b0);
    chk("midnight_day", int'(day24), 1);
    chk("midnight_hh12", int'(hh12), 'h12);
    run(1, 1'b0, 1'b0, 1'b0);
    chk("day_one_cycle", int'(day24), 0);

    // 12 h: 11:59:59 AM -> 12:00:00 PM, 12:59:59 PM -> 01:00:00 PM
    run(1, 1'b0, 1'b1, 1'b0);
    run(11, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b1, 1'b0);
    run(59, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b1, 1'b0);
    run(60, 1'b1, 1'b0, 1'b0);
    chk("noon_hh12", int'(hh12), 'h12);
    chk("noon_pm", int'(pm12), 1);
    run(2, 1'b0, 1'b1, 1'b0);
    run(59, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b1, 1'b0);
    run(60, 1'b1, 1'b0, 1'b0);
    chk("one_pm_hh12", int'(hh12), 'h01);
    chk("one_pm_pm", int'(pm12), 1);

    // set-mode hour wrap through 23->00 / 11 PM->12 AM, no day pulse
    run(1, 1'b0, 1'b1, 1'b0);
    run(12, 1'b0, 1'b0, 1'b1);
    run(2, 1'b0, 1'b1, 1'b0);
    chk("setwrap_hh24", int'(hh24), 'h01);

    // set sequence with ticks throughout -> 03:01:00
    async_reset("rst3");
    run(1, 1'b1, 1'b1, 1'b0);
    run(3, 1'b1, 1'b0, 1'b1);
    run(1, 1'b1, 1'b1, 1'b0);
    run(61, 1'b1, 1'b0, 1'b1);
    run(1, 1'b1, 1'b1, 1'b0);
    chk("set_hh", int'(hh24), 'h03);
    chk("set_mm", int'(mm24), 'h01);
    chk("set_ss", int'(ss24), 'h00);
    chk("set_ed", int'(ed24), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at step %0d: got timeout, want finish", nstep);
    $fatal(1, "watchdog");
  end

endmodule
